// File: rtl/ifu_fetch_queue.sv
// Sequential instruction-fetch front end: word requests to imem, response FIFO, head slot for the IADU.
// Define IFU_BUS_ERR_EN to carry a per-word bus error to the IADU as o_fetch_fault.
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_decode_busy,
    input  logic        i_hold,
    input  logic        i_inc_by_2,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
`ifdef IFU_BUS_ERR_EN
    input  logic        i_imem_rsp_err,
    output logic        o_fetch_fault,
`endif
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_next
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Handshake: a request transfers on a cycle where o_imem_req_valid && i_imem_req_ready;
    // valid never depends on ready. Responses have no back-pressure: one per accepted request, in order.

    logic [29:0]   waddr_q;
    logic [29:0]   rsp_waddr_q;
    logic          half_q;
    logic          first_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [31:0]   pc_hold_q;

    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [29:0]   addr_mem [FIFO_DEPTH];

    logic          req_fire;
    logic          push;
    logic          pop;
    logic          head_err;
    logic [31:0]   head_pc;
    logic [CW-1:0] outstanding_nxt;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = i_redirect_pc[0];

    // Request is masked in reset so nothing is offered before the first clock after release.
    assign o_imem_req_valid = reset_n && !i_redirect && ((outstanding_q + count_q) < DEPTH_C);
    assign o_imem_addr      = {waddr_q, 2'b00};
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    assign push    = i_imem_rsp_valid && (discard_q == '0) && !i_redirect;
    assign o_valid = (count_q != '0);
    assign pop     = o_valid && !i_decode_busy && !i_hold && !i_redirect;

    // A response landing during a redirect retires its request along with being dropped.
    assign outstanding_nxt = outstanding_q + CW'(req_fire) - CW'(i_imem_rsp_valid);

`ifdef IFU_BUS_ERR_EN
    logic err_mem [FIFO_DEPTH];
    assign head_err      = err_mem[rd_ptr_q];
    assign o_fetch_fault = o_valid && head_err;

    always_ff @(posedge clk) begin
        if (push) begin
            err_mem[wr_ptr_q] <= i_imem_rsp_err;
        end
    end
`else
    assign head_err = 1'b0;
`endif

    assign head_pc = {addr_mem[rd_ptr_q], half_q, 1'b0};

    always_comb begin
        o_inst    = NOP;
        o_pc      = pc_hold_q;
        if (o_valid) begin
            o_pc = head_pc;
            if (!head_err) begin
                o_inst = data_mem[rd_ptr_q];
            end
        end
        // first_q forces a discontinuity so the IADU restarts alignment.
        o_pc_next = first_q ? o_pc : o_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= i_imem_rsp_data;
            addr_mem[wr_ptr_q] <= rsp_waddr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr_q       <= RESET_PC[31:2];
            rsp_waddr_q   <= RESET_PC[31:2];
            half_q        <= RESET_PC[1];
            first_q       <= 1'b1;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pc_hold_q     <= RESET_PC;
        end else begin
            outstanding_q <= outstanding_nxt;
            if (o_valid) begin
                pc_hold_q <= head_pc;
            end
            if (i_redirect) begin
                count_q     <= '0;
                rd_ptr_q    <= '0;
                wr_ptr_q    <= '0;
                discard_q   <= outstanding_nxt;
                waddr_q     <= i_redirect_pc[31:2];
                rsp_waddr_q <= i_redirect_pc[31:2];
                half_q      <= i_redirect_pc[1];
                first_q     <= 1'b1;
            end else begin
                if (i_imem_rsp_valid && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
                if (req_fire) begin
                    waddr_q <= waddr_q + 30'd1;
                end
                if (push) begin
                    wr_ptr_q    <= wr_ptr_q + AW'(1);
                    rsp_waddr_q <= rsp_waddr_q + 30'd1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    first_q  <= 1'b0;
                    if (i_inc_by_2) begin
                        half_q <= 1'b0;
                    end
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

endmodule
